// File: rtl/modred_pkg.sv
// Shared types and helpers for the modular-reduction issue stage.
// Holds the operand width, the special moduli, the request entry layout
// and the modulus bitlength/class function used at enqueue time.
package modred_pkg;

    localparam int DATA_LENGTH = 64;
    localparam int BL_W        = 7;
    localparam int REQ_TAG_W   = 4;

    localparam logic [DATA_LENGTH-1:0] KYBER_Q     = 64'd3329;
    localparam logic [DATA_LENGTH-1:0] DILITHIUM_Q = 64'd8380417;

    typedef enum logic [2:0] {
        MC_GENERIC,
        MC_MERSENNE,
        MC_FERMAT,
        MC_KYBER,
        MC_DILITHIUM
    } mclass_t;

    typedef struct packed {
        logic [DATA_LENGTH-1:0] x;
        logic [DATA_LENGTH-1:0] m;
        logic [BL_W-1:0]        bl;
        mclass_t                mclass;
        logic [REQ_TAG_W-1:0]   tag;
    } req_t;

    typedef struct packed {
        logic [BL_W-1:0] bl;
        mclass_t         mclass;
    } mclass_info_t;

    // Bitlength is MSB index + 1 (0 for m == 0). The class checks run in
    // priority order so the two lattice moduli win over any structural match.
    function automatic mclass_info_t modred_classify(input logic [DATA_LENGTH-1:0] m);
        mclass_info_t    info;
        logic [BL_W-1:0] bl;
        bl = '0;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            if (m[i]) begin
                bl = BL_W'(i + 1);
            end
        end
        info.bl = bl;
        // 1 << 64 wraps to 0 in 64 bits, so the all-ones modulus still matches
        if (m == KYBER_Q) begin
            info.mclass = MC_KYBER;
        end else if (m == DILITHIUM_Q) begin
            info.mclass = MC_DILITHIUM;
        end else if ((bl >= BL_W'(2)) && (m == ((64'd1 << bl) - 64'd1))) begin
            info.mclass = MC_MERSENNE;
        end else if ((bl >= BL_W'(3)) && (m == ((64'd1 << (bl - BL_W'(1))) + 64'd1))) begin
            info.mclass = MC_FERMAT;
        end else begin
            info.mclass = MC_GENERIC;
        end
        return info;
    endfunction

endpackage

// File: rtl/modred_req_fifo.sv
// Request FIFO for the modular-reduction issue stage.
// Synchronous FIFO of req_t entries; pointers carry one extra wrap bit so
// that full and empty are distinguishable. Pushes while full and pops while
// empty are ignored.
module modred_req_fifo
    import modred_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push,
    input  req_t wdata,
    input  logic pop,
    output req_t rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    req_t          mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    // Advance the read and write pointers; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/modred_dispatch.sv
// Issue stage in front of the serial shift-add modular reducer.
// Buffers (x, m, tag) requests, classifies each modulus on entry, runs one
// request at a time through the reducer and returns x mod m with its tag.
// Unsupported (generic) moduli are answered immediately with err = 1.
// Optional build macro MODRED_TIMEOUT_EN adds a WAIT watchdog that answers
// with err = 1 after TIMEOUT_CYCLES cycles without a reducer result.
// TAG_W must not exceed REQ_TAG_W (the FIFO entry tag width).
module modred_dispatch
    import modred_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_LENGTH-1:0] in_x_i,
    input  logic [DATA_LENGTH-1:0] in_m_i,
    input  logic [TAG_W-1:0]       in_tag_i,
    output logic                   red_start_o,
    output logic [DATA_LENGTH-1:0] red_x_o,
    output logic [DATA_LENGTH-1:0] red_m_o,
    output logic [DATA_LENGTH-1:0] red_m_bl_o,
    input  logic                   red_valid_i,
    input  logic [DATA_LENGTH-1:0] red_result_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_LENGTH-1:0] out_result_o,
    output logic [TAG_W-1:0]       out_tag_o,
    output logic [2:0]             out_mclass_o,
    output logic                   out_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                 state_q, state_d;
    req_t                   work_q, work_d;
    logic [DATA_LENGTH-1:0] result_q, result_d;
    logic                   err_q, err_d;
    logic                   ready_en_q;

    mclass_info_t           in_info;
    req_t                   fifo_wdata;
    req_t                   fifo_rdata;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   timeout_hit;

    assign in_info    = modred_classify(in_m_i);
    assign fifo_wdata = '{x:      in_x_i,
                          m:      in_m_i,
                          bl:     in_info.bl,
                          mclass: in_info.mclass,
                          tag:    REQ_TAG_W'(in_tag_i)};

    // ready_en_q keeps in_ready_o low during reset and for the first edge after it
    assign in_ready_o = ready_en_q && !fifo_full;
    assign fifo_push  = in_valid_i && in_ready_o;

    modred_req_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (fifo_push),
        .wdata  (fifo_wdata),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

`ifdef MODRED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;

    // The last permitted WAIT cycle is the one where the count reads TIMEOUT_CYCLES-1.
    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Count cycles spent in WAIT; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else if (state_q != ST_WAIT) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State, work request and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            work_q     <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            result_q   <= result_d;
            err_q      <= err_d;
            ready_en_q <= 1'b1;
        end
    end

    // Next-state logic: pop, issue one start pulse, wait for the result, respond.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        result_d    = result_q;
        err_d       = err_q;
        fifo_pop    = 1'b0;
        red_start_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    work_d   = fifo_rdata;
                    if (fifo_rdata.mclass == MC_GENERIC) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                red_start_o = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (red_valid_i) begin
                    result_d = red_result_i;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end else if (timeout_hit) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign red_x_o      = work_q.x;
    assign red_m_o      = work_q.m;
    assign red_m_bl_o   = DATA_LENGTH'(work_q.bl);
    assign out_valid_o  = (state_q == ST_RESP);
    assign out_result_o = result_q;
    assign out_err_o    = err_q;
    assign out_tag_o    = TAG_W'(work_q.tag);
    assign out_mclass_o = work_q.mclass;

endmodule

// File: tb/tb_modred_dispatch.sv
// Testbench for modred_dispatch: directed requests, a reducer stub, and a
// scoreboard fed by a plain-arithmetic model of bitlength, class and x mod m.
module tb_modred_dispatch;
    import modred_pkg::*;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_x;
    logic [63:0]       in_m;
    logic [TAG_W-1:0]  in_tag;
    logic              red_start_o;
    logic [63:0]       red_x_o;
    logic [63:0]       red_m_o;
    logic [63:0]       red_m_bl_o;
    logic              red_valid;
    logic [63:0]       red_result;
    logic              out_valid_o;
    logic              out_ready;
    logic [63:0]       out_result_o;
    logic [TAG_W-1:0]  out_tag_o;
    logic [2:0]        out_mclass_o;
    logic              out_err_o;

    logic              stub_valid = 1'b0;
    logic [63:0]       stub_result = '0;
    logic              manual_valid = 1'b0;
    logic [63:0]       manual_result = '0;

    assign red_valid  = stub_valid | manual_valid;
    assign red_result = manual_valid ? manual_result : stub_result;

    modred_dispatch #(
        .FIFO_DEPTH     (4),
        .TAG_W          (TAG_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_x_i       (in_x),
        .in_m_i       (in_m),
        .in_tag_i     (in_tag),
        .red_start_o  (red_start_o),
        .red_x_o      (red_x_o),
        .red_m_o      (red_m_o),
        .red_m_bl_o   (red_m_bl_o),
        .red_valid_i  (red_valid),
        .red_result_i (red_result),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready),
        .out_result_o (out_result_o),
        .out_tag_o    (out_tag_o),
        .out_mclass_o (out_mclass_o),
        .out_err_o    (out_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] result;
        logic [3:0]  tag;
        logic [2:0]  mclass;
        logic        err;
    } resp_t;

    typedef struct {
        logic [63:0] x;
        logic [63:0] m;
        logic [63:0] bl;
    } iss_t;

    resp_t       exp_q[$];
    iss_t        iss_q[$];
    resp_t       resp_log[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          start_count = 0;
    int          resp_count = 0;
    bit          stub_enable = 1'b1;
    int          stub_latency = 3;
    bit          expect_timeout = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Reference model: bitlength is the smallest n with m < 2^n; class by
    // priority; result is x mod m for supported moduli, 0 with err otherwise.
    function automatic void modelRequest(input logic [63:0] x, input logic [63:0] m,
                                         output resp_t r, output int bl);
        logic [64:0] mp1;
        mclass_t     mc;
        bl = 0;
        while (bl < 64 && (m >> bl) != 64'd0) bl++;
        mp1 = {1'b0, m} + 65'd1;
        if (m == 64'd3329)                                          mc = MC_KYBER;
        else if (m == 64'd8380417)                                  mc = MC_DILITHIUM;
        else if (bl >= 2 && mp1 == (65'd1 << bl))                   mc = MC_MERSENNE;
        else if (bl >= 3 && {1'b0, m} == (65'd1 << (bl - 1)) + 65'd1) mc = MC_FERMAT;
        else                                                        mc = MC_GENERIC;
        r.mclass = mc;
        r.tag    = '0;
        if (mc == MC_GENERIC) begin
            r.result = '0;
            r.err    = 1'b1;
        end else begin
            r.result = x % m;
            r.err    = 1'b0;
        end
    endfunction

    // Drive one request starting just after a rising edge; ends just after the
    // edge that completed (or abandoned) it, so calls can go back to back.
    task automatic applyStimulus(input logic [63:0] x, input logic [63:0] m, input logic [3:0] tag,
                                 input int max_wait, output bit accepted);
        resp_t r;
        iss_t  s;
        int    bl;
        int    waited;
        modelRequest(x, m, r, bl);
        r.tag = tag;
        if (expect_timeout) begin
            r.result = '0;
            r.err    = 1'b1;
        end
        in_valid = 1'b1;
        in_x     = x;
        in_m     = m;
        in_tag   = tag;
        accepted = 1'b0;
        waited   = 0;
        while (!accepted && waited < max_wait) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            else waited++;
        end
        if (accepted) begin
            exp_q.push_back(r);
            if (r.mclass != MC_GENERIC) begin
                s.x  = x;
                s.m  = m;
                s.bl = 64'(bl);
                iss_q.push_back(s);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitResp(input int target, input string name);
        int n;
        n = 0;
        while (resp_count < target && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput(name, 64'(resp_count), 64'(target));
    endtask

    // Reducer stub: answers each start with x mod m after stub_latency edges.
    always begin
        logic [63:0] sx;
        logic [63:0] sm;
        @(negedge clk);
        if (rst_n && red_start_o && stub_enable) begin
            sx = red_x_o;
            sm = red_m_o;
            repeat (stub_latency) @(posedge clk);
            #1;
            stub_valid  = 1'b1;
            stub_result = (sm != 64'd0) ? (sx % sm) : 64'd0;
            @(posedge clk);
            #1;
            stub_valid  = 1'b0;
            stub_result = '0;
        end
    end

    // Compare process: start pulses against issued requests, held response
    // fields while stalled, and each accepted response against the scoreboard.
    resp_t       hold;
    bit          hold_valid = 1'b0;
    resp_t       cur_exp;
    resp_t       cur_act;
    iss_t        cur_iss;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_valid = 1'b0;
        end else begin
            if (red_start_o) begin
                start_count++;
                if (iss_q.size() == 0) begin
                    checkOutput("spurious red_start", 64'd1, 64'd0);
                end else begin
                    cur_iss = iss_q.pop_front();
                    checkOutput("red_x", red_x_o, cur_iss.x);
                    checkOutput("red_m", red_m_o, cur_iss.m);
                    checkOutput("red_m_bl", red_m_bl_o, cur_iss.bl);
                end
            end
            if (hold_valid) begin
                checkOutput("held out_valid", 64'(out_valid_o), 64'd1);
                checkOutput("held out_result", out_result_o, hold.result);
                checkOutput("held out_tag", 64'(out_tag_o), 64'(hold.tag));
                checkOutput("held out_err", 64'(out_err_o), 64'(hold.err));
            end
            if (out_valid_o && out_ready) begin
                resp_count++;
                cur_act.result = out_result_o;
                cur_act.tag    = out_tag_o;
                cur_act.mclass = out_mclass_o;
                cur_act.err    = out_err_o;
                resp_log.push_back(cur_act);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected response", 64'd1, 64'd0);
                end else begin
                    cur_exp = exp_q.pop_front();
                    checkOutput("out_result", out_result_o, cur_exp.result);
                    checkOutput("out_tag", 64'(out_tag_o), 64'(cur_exp.tag));
                    checkOutput("out_mclass", 64'(out_mclass_o), 64'(cur_exp.mclass));
                    checkOutput("out_err", 64'(out_err_o), 64'(cur_exp.err));
                end
            end
            hold_valid  = out_valid_o && !out_ready;
            hold.result = out_result_o;
            hold.tag    = out_tag_o;
            hold.err    = out_err_o;
            hold.mclass = out_mclass_o;
        end
    end

    initial begin
        resp_t r;
        int    bl;
        bit    acc;
        bit    acc_all;
        int    s0;
        int    r0;
        int    n;

        in_valid  = 1'b0;
        in_x      = '0;
        in_m      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;

        // Pin the model to hand-computed values
        modelRequest(64'd100, 64'd7, r, bl);
        checkOutput("model m=7 bl", 64'(bl), 64'd3);
        checkOutput("model m=7 class", 64'(r.mclass), 64'd1);
        checkOutput("model 100 mod 7", r.result, 64'd2);
        modelRequest(64'd1000, 64'd17, r, bl);
        checkOutput("model m=17 class", 64'(r.mclass), 64'd2);
        checkOutput("model 1000 mod 17", r.result, 64'd14);
        modelRequest(64'd5000, 64'd3329, r, bl);
        checkOutput("model kyber", r.result, 64'd1671);
        modelRequest(64'd9000000, 64'd8380417, r, bl);
        checkOutput("model dilithium", r.result, 64'd619583);
        modelRequest(64'd55, 64'd10, r, bl);
        checkOutput("model m=10 err", 64'(r.err), 64'd1);
        modelRequest(64'd55, 64'd1, r, bl);
        checkOutput("model m=1 class", 64'(r.mclass), 64'd0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset out_valid", 64'(out_valid_o), 64'd0);
        checkOutput("reset red_start", 64'(red_start_o), 64'd0);
        checkOutput("reset red_m_bl", red_m_bl_o, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("in_ready after release", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // 1: Mersenne
        s0 = start_count;
        applyStimulus(64'd100, 64'd7, 4'd1, 50, acc);
        waitResp(1, "t1 response count");
        checkOutput("t1 result", resp_log[0].result, 64'd2);
        checkOutput("t1 class", 64'(resp_log[0].mclass), 64'(MC_MERSENNE));
        checkOutput("t1 red_m_bl", red_m_bl_o, 64'd3);
        checkOutput("t1 start pulses", 64'(start_count - s0), 64'd1);

        // 2: Fermat
        applyStimulus(64'd1000, 64'd17, 4'd2, 50, acc);
        waitResp(2, "t2 response count");
        checkOutput("t2 result", resp_log[1].result, 64'd14);
        checkOutput("t2 red_m_bl", red_m_bl_o, 64'd5);

        // 3: Kyber, Dilithium, smallest Mersenne, all-ones modulus
        applyStimulus(64'd5000, 64'd3329, 4'd3, 50, acc);
        applyStimulus(64'd9000000, 64'd8380417, 4'd4, 50, acc);
        applyStimulus(64'd10, 64'd3, 4'd5, 50, acc);
        applyStimulus(64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 4'd6, 50, acc);
        waitResp(6, "t3 response count");
        checkOutput("t3 kyber", resp_log[2].result, 64'd1671);
        checkOutput("t3 dilithium", resp_log[3].result, 64'd619583);
        checkOutput("t3 dilithium class", 64'(resp_log[3].mclass), 64'(MC_DILITHIUM));
        checkOutput("t3 m=3 result", resp_log[4].result, 64'd1);
        checkOutput("t3 all-ones bl", red_m_bl_o, 64'd64);

        // 4: generic modulus, then a supported one behind it
        s0 = start_count;
        applyStimulus(64'd55, 64'd10, 4'd7, 50, acc);
        applyStimulus(64'd50, 64'd7, 4'd8, 50, acc);
        waitResp(8, "t4 response count");
        checkOutput("t4 generic err", 64'(resp_log[6].err), 64'd1);
        checkOutput("t4 generic result", resp_log[6].result, 64'd0);
        checkOutput("t4 follow-up result", resp_log[7].result, 64'd1);
        checkOutput("t4 start pulses", 64'(start_count - s0), 64'd1);

        // 5: back-pressure fills one in flight plus four buffered
        out_ready = 1'b0;
        acc_all = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(64'(1000 + i), 64'd17, 4'(9 + i), 20, acc);
            acc_all = acc_all & acc;
        end
        checkOutput("t5 five accepted", 64'(acc_all), 64'd1);
        applyStimulus(64'd2000, 64'd17, 4'd15, 5, acc);
        checkOutput("t5 sixth refused", 64'(acc), 64'd0);
        checkOutput("t5 in_ready low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        waitResp(13, "t5 response count");
        for (int i = 0; i < 5; i++) begin
            checkOutput("t5 tag order", 64'(resp_log[8 + i].tag), 64'(9 + i));
        end

        // 6: reset during WAIT discards the request
        stub_enable = 1'b0;
        s0 = start_count;
        applyStimulus(64'd100, 64'd7, 4'd3, 50, acc);
        n = 0;
        while (start_count == s0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("t6 start seen", 64'(start_count), 64'(s0 + 1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        iss_q.delete();
        @(negedge clk);
        checkOutput("t6 reset in_ready", 64'(in_ready), 64'd0);
        checkOutput("t6 reset red_x|red_m|bl", red_x_o | red_m_o | red_m_bl_o, 64'd0);
        checkOutput("t6 reset outputs", out_result_o | 64'(out_err_o) | 64'(out_tag_o) | 64'(out_mclass_o) | 64'(out_valid_o), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t6 in_ready after release", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        r0 = resp_count;
        s0 = start_count;
        manual_valid  = 1'b1;
        manual_result = 64'd77;
        @(posedge clk);
        #1;
        manual_valid  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t6 stray red_valid no response", 64'(resp_count), 64'(r0));
        checkOutput("t6 out_valid idle", 64'(out_valid_o), 64'd0);
        checkOutput("t6 no start", 64'(start_count), 64'(s0));
        stub_enable = 1'b1;
        applyStimulus(64'd1000, 64'd17, 4'd7, 50, acc);
        waitResp(r0 + 1, "t6 recovery response count");
        checkOutput("t6 recovery result", resp_log[r0].result, 64'd14);

`ifdef MODRED_TIMEOUT_EN
        // Watchdog: reducer never answers
        stub_enable    = 1'b0;
        expect_timeout = 1'b1;
        r0 = resp_count;
        applyStimulus(64'd100, 64'd7, 4'd9, 50, acc);
        expect_timeout = 1'b0;
        n = 0;
        while (!red_start_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid_o && n < 200);
        checkOutput("timeout WAIT cycles", 64'(n - 1), 64'(TIMEOUT));
        @(posedge clk);
        #1;
        waitResp(r0 + 1, "timeout response count");
        checkOutput("timeout err", 64'(resp_log[r0].err), 64'd1);
        stub_enable = 1'b1;
`endif

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
